// File: rtl/systolic_feeder.sv
// systolic_feeder: job sequencer for one systolic_array instance.
// Buffers an A (column-per-k) and B (row-per-k) operand set, streams it into
// the array edges, drains the array pipeline with zero beats and latches the
// accumulator bus.
// Optional feature macro: FEEDER_AUTOCLEAR_EN (one-cycle array clear before
// every job; without it consecutive jobs accumulate into the array).
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | load port open, waiting for a start with a legal k_len
// S_CLEAR   | array held in reset for one cycle (FEEDER_AUTOCLEAR_EN)
// S_STREAM  | presenting buffered A column / B row number cnt
// S_DRAIN   | zero beats flushing the skew and pass-through registers
// S_CAPTURE | array stopped, accumulator bus latched at the closing edge

module systolic_feeder #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int ACC_W = 2*W+4,
  parameter int K_MAX = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic                          ld_sel,
  input  logic [$clog2(K_MAX)-1:0]      ld_k,
  input  logic [N*W-1:0]                ld_data,
  input  logic                          start,
  input  logic [$clog2(K_MAX):0]        k_len,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic                          arr_rst,
  output logic                          arr_en,
  output logic [N*W-1:0]                a_vec_flat,
  output logic [N*W-1:0]                b_vec_flat,
  input  logic [N*N*ACC_W-1:0]          c_in_flat,
  output logic [N*N*ACC_W-1:0]          c_res_flat
);

  localparam int KW      = $clog2(K_MAX);
  localparam int CNT_MAX = (K_MAX > 2*N) ? K_MAX : 2*N;
  localparam int CNT_W   = $clog2(CNT_MAX);

  localparam logic [KW:0]      K_MAX_L    = (KW+1)'(K_MAX);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(2*N-2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_CAPTURE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [KW:0]             k_q, k_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;
  logic                    arr_rst_q, arr_rst_d;
  logic                    arr_en_q, arr_en_d;
  logic                    ld_ready_q, ld_ready_d;
  logic [N*W-1:0]          a_vec_q, a_vec_d;
  logic [N*W-1:0]          b_vec_q, b_vec_d;
  logic [N*N*ACC_W-1:0]    c_res_q, c_res_d;

  // Operand buffers are deliberately not reset: contents survive jobs and resets.
  logic [N*W-1:0]          abuf_q [K_MAX];
  logic [N*W-1:0]          bbuf_q [K_MAX];

  logic [KW:0]             ld_k_ext;
  logic                    buf_we;
  logic [CNT_W-1:0]        stream_last;
  logic [KW-1:0]           beat_idx;
  logic [N*W-1:0]          a_rd;
  logic [N*W-1:0]          b_rd;

  assign ld_k_ext    = {1'b0, ld_k};
  assign buf_we      = ld_valid & ld_ready_q & (ld_k_ext < K_MAX_L);
  assign stream_last = CNT_W'(k_q - 1'b1);
  assign beat_idx    = cnt_d[KW-1:0];

  // Load beats land in the buffer selected by ld_sel; out-of-range k is dropped.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      if (ld_sel) begin
        bbuf_q[ld_k] <= ld_data;
      end else begin
        abuf_q[ld_k] <= ld_data;
      end
    end
  end

  // Buffer read for the next beat, forwarding a beat written on the start edge.
  always_comb begin
    a_rd = abuf_q[beat_idx];
    b_rd = bbuf_q[beat_idx];
    if (buf_we && (ld_k == beat_idx)) begin
      if (ld_sel) begin
        b_rd = ld_data;
      end else begin
        a_rd = ld_data;
      end
    end
  end

  // Next-state, beat counter, job length latch, pulses and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    c_res_d = c_res_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if ((k_len == '0) || (k_len > K_MAX_L)) begin
            err_d = 1'b1;
          end else begin
            k_d   = k_len;
            cnt_d = '0;
`ifdef FEEDER_AUTOCLEAR_EN
            state_d = S_CLEAR;
`else
            state_d = S_STREAM;
`endif
          end
        end
      end
      S_CLEAR: begin
        state_d = S_STREAM;
        cnt_d   = '0;
      end
      S_STREAM: begin
        if (cnt_q == stream_last) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CAPTURE: begin
        state_d = S_IDLE;
        c_res_d = c_in_flat;
        done_d  = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the state being entered so they line
  // up with the state they describe.
  always_comb begin
    busy_d     = (state_d != S_IDLE);
    ld_ready_d = (state_d == S_IDLE);
    arr_rst_d  = (state_d == S_CLEAR);
    arr_en_d   = (state_d == S_STREAM) || (state_d == S_DRAIN);
    a_vec_d    = '0;
    b_vec_d    = '0;
    if (state_d == S_STREAM) begin
      a_vec_d = a_rd;
      b_vec_d = b_rd;
    end
  end

  // State and output registers; reset holds the array in reset too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      k_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      arr_rst_q  <= 1'b1;
      arr_en_q   <= 1'b0;
      ld_ready_q <= 1'b1;
      a_vec_q    <= '0;
      b_vec_q    <= '0;
      c_res_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      k_q        <= k_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      arr_rst_q  <= arr_rst_d;
      arr_en_q   <= arr_en_d;
      ld_ready_q <= ld_ready_d;
      a_vec_q    <= a_vec_d;
      b_vec_q    <= b_vec_d;
      c_res_q    <= c_res_d;
    end
  end

  assign ld_ready   = ld_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign arr_rst    = arr_rst_q;
  assign arr_en     = arr_en_q;
  assign a_vec_flat = a_vec_q;
  assign b_vec_flat = b_vec_q;
  assign c_res_flat = c_res_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with a behavioural output-stationary
// systolic array (input skew, pass-through registers, product register).
module tb_systolic_feeder;

  localparam int N = 2, W = 8, ACC_W = 20, K_MAX = 16, KW = 4;
`ifdef FEEDER_AUTOCLEAR_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 1;
`endif
  localparam logic AUTOCLR = (EXTRA == 2);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ld_valid = 1'b0, ld_ready, ld_sel = 1'b0;
  logic [KW-1:0] ld_k = '0;
  logic [N*W-1:0] ld_data = '0;
  logic start = 1'b0;
  logic [KW:0] k_len = '0;
  logic busy, done, err, arr_rst, arr_en;
  logic [N*W-1:0] a_vec_flat, b_vec_flat;
  logic [N*N*ACC_W-1:0] c_in_flat, c_res_flat;

  int passed = 0;
  int total  = 0;

  systolic_feeder #(.N(N), .W(W), .ACC_W(ACC_W), .K_MAX(K_MAX)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_sel(ld_sel), .ld_k(ld_k), .ld_data(ld_data), .start(start),
    .k_len(k_len), .busy(busy), .done(done), .err(err), .arr_rst(arr_rst),
    .arr_en(arr_en), .a_vec_flat(a_vec_flat), .b_vec_flat(b_vec_flat),
    .c_in_flat(c_in_flat), .c_res_flat(c_res_flat)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural systolic array ----------------
  logic signed [W-1:0]     a_in [N], b_in [N], skew_a [N], skew_b [N];
  logic signed [W-1:0]     dla [N][N], dlb [N][N], ar [N][N], br [N][N];
  logic signed [W-1:0]     a_x [N][N], b_x [N][N];
  logic signed [ACC_W-1:0] prod_x [N][N], prod [N][N], acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_in[i] = a_vec_flat[i*W +: W];
      b_in[i] = b_vec_flat[i*W +: W];
    end
    skew_a[0] = a_in[0];
    skew_b[0] = b_in[0];
    for (int i = 1; i < N; i++) begin
      skew_a[i] = dla[i][i-1];
      skew_b[i] = dlb[i][i-1];
    end
    for (int i = 0; i < N; i++) begin
      a_x[i][0] = skew_a[i];
      b_x[0][i] = skew_b[i];
      for (int j = 1; j < N; j++) begin
        a_x[i][j] = ar[i][j-1];
        b_x[j][i] = br[j-1][i];
      end
    end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        prod_x[i][j] = ACC_W'(a_x[i][j]) * ACC_W'(b_x[i][j]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        c_in_flat[(i*N+j)*ACC_W +: ACC_W] = acc[i][j];
  end

  always @(posedge clk) begin
    if (arr_rst) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          dla[i][j] <= '0; dlb[i][j] <= '0; ar[i][j] <= '0; br[i][j] <= '0;
          prod[i][j] <= '0; acc[i][j] <= '0;
        end
    end else if (arr_en) begin
      for (int i = 0; i < N; i++) begin
        dla[i][0] <= a_in[i];
        dlb[i][0] <= b_in[i];
        for (int s = 1; s < N; s++) begin
          dla[i][s] <= dla[i][s-1];
          dlb[i][s] <= dlb[i][s-1];
        end
      end
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) begin
          ar[i][j]   <= a_x[i][j];
          br[i][j]   <= b_x[i][j];
          prod[i][j] <= prod_x[i][j];
          acc[i][j]  <= acc[i][j] + prod[i][j];
        end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [N*N*ACC_W-1:0] cpack(input int c00, c01, c10, c11);
    return {20'(c11), 20'(c10), 20'(c01), 20'(c00)};
  endfunction

  task automatic fresh();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic load_beat(input logic sel, input int k, input int hi, input int lo);
    ld_valid = 1'b1; ld_sel = sel; ld_k = KW'(k); ld_data = {8'(hi), 8'(lo)};
    @(posedge clk); #1;
    ld_valid = 1'b0;
  endtask

  // A columns {A[1][k],A[0][k]}, B rows {B[k][1],B[k][0]}
  task automatic load_basic();
    load_beat(0, 0, 3, 1); load_beat(0, 1, 4, 2);
    load_beat(1, 0, 6, 5); load_beat(1, 1, 8, 7);
  endtask

  task automatic load_signed();
    load_beat(0, 0, 3, -1); load_beat(0, 1, -4, 2);
    load_beat(1, 0, -6, 5); load_beat(1, 1, 8, -7);
  endtask

  task automatic run_job(input logic [KW:0] kl, input bit disturb,
                         output int lat, output logic rst_c1, output logic en_c1,
                         output logic [N*W-1:0] a_first, output logic [N*W-1:0] b_first,
                         output bit err_seen, output bit busy_gap, output logic rdy_c2);
    int n;
    start = 1'b1; k_len = kl;
    @(posedge clk); #1;
    start = 1'b0; ld_valid = 1'b0;
    n = 1; lat = 0; err_seen = 0; busy_gap = 0; rdy_c2 = 1'bx;
    a_first = 'x; b_first = 'x;
    rst_c1 = arr_rst; en_c1 = arr_en;
    while (n < 200) begin
      if (n == EXTRA) begin a_first = a_vec_flat; b_first = b_vec_flat; end
      if (err) err_seen = 1;
      if (done) begin lat = n; break; end
      if (!busy) busy_gap = 1;
      if (disturb && n == 2) begin
        rdy_c2 = ld_ready;
        start = 1'b1; k_len = 2; ld_valid = 1'b1; ld_sel = 1'b0; ld_k = '0; ld_data = '1;
      end
      if (disturb && n == 3) begin start = 1'b0; ld_valid = 1'b0; end
      @(posedge clk); #1;
      n++;
    end
  endtask

  localparam logic [N*N*ACC_W-1:0] C_BASIC = cpack(19, 22, 43, 50);

  // ---------------- tests ----------------
  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL reset_done_err: got %b%b want 00", done, err); else passed++;
    total++; if (arr_en !== 1'b0) $display("FAIL reset_arr_en: got %b want 0", arr_en); else passed++;
    total++; if (arr_rst !== 1'b1) $display("FAIL reset_arr_rst: got %b want 1", arr_rst); else passed++;
    total++; if (a_vec_flat !== '0 || b_vec_flat !== '0) $display("FAIL reset_vecs: got %h %h want 0", a_vec_flat, b_vec_flat); else passed++;
    total++; if (c_res_flat !== '0) $display("FAIL reset_c_res: got %h want 0", c_res_flat); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    total++; if (arr_rst !== 1'b0) $display("FAIL release_arr_rst: got %b want 0", arr_rst); else passed++;
    total++; if (ld_ready !== 1'b1) $display("FAIL release_ld_ready: got %b want 1", ld_ready); else passed++;
  endtask

  task automatic test_basic();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    fresh();
    load_basic();
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (lat !== 2 + 2*N + EXTRA) $display("FAIL basic_latency: got %0d want %0d", lat, 2 + 2*N + EXTRA); else passed++;
    total++; if (c_res_flat !== C_BASIC) $display("FAIL basic_c: got %h want %h", c_res_flat, C_BASIC); else passed++;
    total++; if (r1 !== AUTOCLR) $display("FAIL basic_arr_rst_t1: got %b want %b", r1, AUTOCLR); else passed++;
    total++; if (e1 !== !AUTOCLR) $display("FAIL basic_arr_en_t1: got %b want %b", e1, !AUTOCLR); else passed++;
    total++; if (af !== 16'h0301 || bf !== 16'h0605) $display("FAIL basic_first_beat: got %h %h want 0301 0605", af, bf); else passed++;
    total++; if (bg !== 1'b0 || es !== 1'b0) $display("FAIL basic_busy_err: got gap=%b err=%b want 0 0", bg, es); else passed++;
    @(posedge clk); #1;
    total++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse: got done=%b busy=%b want 0 0", done, busy); else passed++;
  endtask

  task automatic test_signed();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    fresh();
    load_signed();
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (c_res_flat !== cpack(-19, 22, 43, -50)) $display("FAIL signed_c: got %h want %h", c_res_flat, cpack(-19, 22, 43, -50)); else passed++;
  endtask

  task automatic test_k1();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    fresh();
    run_job(1, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (lat !== 1 + 2*N + EXTRA) $display("FAIL k1_latency: got %0d want %0d", lat, 1 + 2*N + EXTRA); else passed++;
    total++; if (c_res_flat !== cpack(-5, 6, 15, -18)) $display("FAIL k1_c: got %h want %h", c_res_flat, cpack(-5, 6, 15, -18)); else passed++;
  endtask

  task automatic test_err();
    logic [KW:0] bad [2];
    bad[0] = 0; bad[1] = K_MAX + 1;
    for (int t = 0; t < 2; t++) begin
      start = 1'b1; k_len = bad[t];
      @(posedge clk); #1;
      start = 1'b0;
      total++; if (err !== 1'b1 || busy !== 1'b0) $display("FAIL err_pulse_%0d: got err=%b busy=%b want 1 0", bad[t], err, busy); else passed++;
      @(posedge clk); #1;
      total++; if (err !== 1'b0 || busy !== 1'b0) $display("FAIL err_clear_%0d: got err=%b busy=%b want 0 0", bad[t], err, busy); else passed++;
      total++; if (c_res_flat !== cpack(-5, 6, 15, -18)) $display("FAIL err_c_kept_%0d: got %h", bad[t], c_res_flat); else passed++;
    end
  endtask

  task automatic test_kmax();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    run_job(K_MAX, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (lat !== K_MAX + 2*N + EXTRA) $display("FAIL kmax_latency: got %0d want %0d", lat, K_MAX + 2*N + EXTRA); else passed++;
    total++; if (es !== 1'b0) $display("FAIL kmax_err: got %b want 0", es); else passed++;
  endtask

  task automatic test_busy_ignore();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    fresh();
    load_basic();
    run_job(2, 1, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (rdy !== 1'b0) $display("FAIL busy_ld_ready: got %b want 0", rdy); else passed++;
    total++; if (es !== 1'b0) $display("FAIL busy_start_err: got %b want 0", es); else passed++;
    total++; if (lat !== 2 + 2*N + EXTRA) $display("FAIL busy_latency: got %0d want %0d", lat, 2 + 2*N + EXTRA); else passed++;
    total++; if (c_res_flat !== C_BASIC) $display("FAIL busy_c: got %h want %h", c_res_flat, C_BASIC); else passed++;
    fresh();
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (c_res_flat !== C_BASIC) $display("FAIL busy_buf_kept: got %h want %h", c_res_flat, C_BASIC); else passed++;
  endtask

  task automatic test_reset_mid();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg, dseen;
    fresh();
    load_basic();
    start = 1'b1; k_len = 2;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (EXTRA + 2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || arr_en !== 1'b0 || done !== 1'b0) $display("FAIL midrst_ctrl: got busy=%b en=%b done=%b want 0 0 0", busy, arr_en, done); else passed++;
    total++; if (arr_rst !== 1'b1) $display("FAIL midrst_arr_rst: got %b want 1", arr_rst); else passed++;
    total++; if (a_vec_flat !== '0 || b_vec_flat !== '0) $display("FAIL midrst_vecs: got %h %h want 0", a_vec_flat, b_vec_flat); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    dseen = 0;
    repeat (20) begin @(posedge clk); #1; if (done) dseen = 1; end
    total++; if (dseen !== 1'b0) $display("FAIL midrst_no_done: got %b want 0", dseen); else passed++;
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (c_res_flat !== C_BASIC) $display("FAIL midrst_rerun_c: got %h want %h", c_res_flat, C_BASIC); else passed++;
  endtask

  task automatic test_start_with_load();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    fresh();
    load_basic();
    ld_valid = 1'b1; ld_sel = 1'b0; ld_k = '0; ld_data = '0;
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (lat !== 2 + 2*N + EXTRA) $display("FAIL startld_latency: got %0d want %0d", lat, 2 + 2*N + EXTRA); else passed++;
    total++; if (c_res_flat !== cpack(14, 16, 28, 32)) $display("FAIL startld_c: got %h want %h", c_res_flat, cpack(14, 16, 28, 32)); else passed++;
  endtask

  task automatic test_back_to_back();
    int lat; logic r1, e1, rdy; logic [N*W-1:0] af, bf; bit es, bg;
    logic [N*N*ACC_W-1:0] exp2;
    exp2 = AUTOCLR ? C_BASIC : cpack(38, 44, 86, 100);
    fresh();
    load_basic();
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (c_res_flat !== C_BASIC) $display("FAIL b2b_first_c: got %h want %h", c_res_flat, C_BASIC); else passed++;
    run_job(2, 0, lat, r1, e1, af, bf, es, bg, rdy);
    total++; if (lat !== 2 + 2*N + EXTRA) $display("FAIL b2b_latency: got %0d want %0d", lat, 2 + 2*N + EXTRA); else passed++;
    total++; if (c_res_flat !== exp2) $display("FAIL b2b_second_c: got %h want %h", c_res_flat, exp2); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_k1();
    test_err();
    test_kmax();
    test_busy_ignore();
    test_reset_mid();
    test_start_with_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Job sequencer that drives the edge ports of `systolic_array` (A/B operand streams, array enable, array clear) and captures its accumulator bus.
- Buffers an N×K A matrix and a K×N B matrix loaded over a ready/valid write port.
- On `start`, clears the array, streams K operand beats, and drains the skew and pass-through pipeline with zero beats.
- Latches the N×N result and pulses `done`.
- Sits between the host/DMA side and one array instance.

## Interface
Parameters:
- `N`, 2, array dimension; must match the array.
- `W`, 8, operand width (two's complement, carried as raw bits).
- `ACC_W`, 2*W+4, accumulator width; must match the array.
- `K_MAX`, 16, max inner dimension (buffer depth).

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `ld_valid`  in  1  load beat valid.
- `ld_ready`  out  1  load beat accepted when `ld_valid & ld_ready`.
- `ld_sel`  in  1  0 = A column, 1 = B row.
- `ld_k`  in  $clog2(K_MAX)  inner index k.
- `ld_data`  in  N*W  packed `{x[N-1],...,x[0]}`. Meaning: A[i][k] at slice i for an A column, B[k][j] at slice j for a B row.
- `start`  in  1  launch job (sampled only in IDLE).
- `k_len`  in  $clog2(K_MAX)+1  inner dimension K, sampled with `start`.
- `busy`  out  1  job in progress.
- `done`  out  1  one-cycle pulse, result valid.
- `err`  out  1  one-cycle pulse, start rejected.
- `arr_rst`  out  1  to array `rst`.
- `arr_en`  out  1  to array `en`.
- `a_vec_flat`  out  N*W  to array.
- `b_vec_flat`  out  N*W  to array.
- `c_in_flat`  in  N*N*ACC_W  from array `C_flat`, row-major.
- `c_res_flat`  out  N*N*ACC_W  captured result, row-major.

## Operation
- Buffers:
  - A buffer and B buffer, each K_MAX entries of N*W bits, indexed by k.
  - Not cleared by reset; contents persist across jobs.
- Loading: `ld_ready` = 1 in IDLE only. Beats with `ld_k >= K_MAX` are accepted and discarded.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, CAPTURE.
- IDLE:
  - `start` with 1 <= `k_len` <= K_MAX: go to CLEAR, latch K.
  - `start` with `k_len` = 0 or > K_MAX: stay in IDLE, pulse `err`.
  - `start` and `ld_valid` together: the load beat is accepted and the start is also taken.
- CLEAR (1 cycle): `arr_rst` = 1, `arr_en` = 0. Go to STREAM, beat counter = 0.
- STREAM (K cycles):
  - `arr_en` = 1.
  - `a_vec_flat` = Abuf[cnt], `b_vec_flat` = Bbuf[cnt].
  - At cnt = K-1, go to DRAIN, counter = 0.
- DRAIN (2N-1 cycles): `arr_en` = 1, both vectors all-zero. Zero products leave accumulators unchanged.
- CAPTURE (1 cycle): `arr_en` = 0, `c_res_flat` <= `c_in_flat`. Go to IDLE, `done` = 1 on the following cycle.
- `busy` = 1 in CLEAR through CAPTURE.
- Outside STREAM, `a_vec_flat` and `b_vec_flat` are zero.
- No arithmetic happens in this block. K_MAX·(2^(W-1))² must fit in ACC_W; the integrator checks this.
- `start` while busy: ignored, no `err`.

## Timing
- Reset (async assert, sync release):
  - state = IDLE.
  - `busy`, `done`, `err`, `arr_en` = 0.
  - `arr_rst` = 1 while `rst` is high, 0 after.
  - `a_vec_flat`, `b_vec_flat`, `c_res_flat` = 0.
- Registered outputs: all outputs come from registers.
- `start` sampled at edge T:
  - `arr_rst` high in cycle T+1.
  - Stream beats in T+2 .. T+1+K.
  - Drain in T+2+K .. T+K+2N.
  - Capture edge ends cycle T+K+2N+1.
  - `done` high in cycle T+K+2N+2. Total latency K+2N+2.
- `err` high in cycle T+1 after a rejected start.
- Reset mid-job: the FSM drops to IDLE immediately, `arr_rst` is forced high, and no `done` is issued.

## Configuration
- `FEEDER_AUTOCLEAR_EN` defined: CLEAR state present, as above.
- `FEEDER_AUTOCLEAR_EN` undefined:
  - CLEAR is skipped. IDLE goes directly to STREAM, so latency is K+2N+1.
  - `arr_rst` follows `rst` only, so consecutive jobs accumulate into the array (chunked K larger than K_MAX).

## Test plan
- N=2, W=8, A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, start → `done` 8 cycles after the start edge, `c_res_flat` = {50,43,22,19} (C11,C10,C01,C00).
- Signed operands: A=[[-1,2],[3,-4]], B=[[5,-6],[-7,8]] → C = [[-19,22],[43,-50]].
- `k_len`=0 and `k_len`=K_MAX+1 → `err` pulse, `busy` stays 0, `c_res_flat` unchanged.
- `start` pulsed during STREAM → ignored; `ld_valid` during busy → `ld_ready`=0, buffers unchanged.
- `rst` asserted in DRAIN → outputs at reset values within the same cycle, no `done`. A new job afterwards gives the correct C.
- Two back-to-back identical jobs → same C with AUTOCLEAR; with `FEEDER_AUTOCLEAR_EN` undefined, the second C = 2× the first.
